// File: rtl/bp_table_arbiter_if.sv
// Purpose: groups the lookup, update, flush/status and table-port signals of bp_table_arbiter.
// Ports: slave = arbiter view (requests in, table commands out); master = surrounding logic / table.
// Signal suffixes are relative to the arbiter, so *_i is driven by the master side.
interface bp_table_arbiter_if #(
  parameter int IDX_W = 8
);
  // control / status
  logic             flush_i;
  logic             init_done_o;

  // fetch lookup channel
  logic             lkp_valid_i;
  logic [IDX_W-1:0] lkp_idx_i;
  logic             lkp_ready_o;
  logic             lkp_rsp_valid_o;
  logic [1:0]       lkp_rsp_state_o;
  logic             lkp_rsp_taken_o;

  // resolved-branch update channel
  logic             upd_valid_i;
  logic [IDX_W-1:0] upd_idx_i;
  logic             upd_taken_i;
  logic             upd_ready_o;

  // single-port table
  logic             tbl_req_o;
  logic             tbl_we_o;
  logic [IDX_W-1:0] tbl_addr_o;
  logic [1:0]       tbl_wdata_o;
  logic [1:0]       tbl_rdata_i;

  modport slave (
    input  flush_i,
    input  lkp_valid_i, lkp_idx_i,
    input  upd_valid_i, upd_idx_i, upd_taken_i,
    input  tbl_rdata_i,
    output init_done_o,
    output lkp_ready_o, lkp_rsp_valid_o, lkp_rsp_state_o, lkp_rsp_taken_o,
    output upd_ready_o,
    output tbl_req_o, tbl_we_o, tbl_addr_o, tbl_wdata_o
  );

  modport master (
    output flush_i,
    output lkp_valid_i, lkp_idx_i,
    output upd_valid_i, upd_idx_i, upd_taken_i,
    output tbl_rdata_i,
    input  init_done_o,
    input  lkp_ready_o, lkp_rsp_valid_o, lkp_rsp_state_o, lkp_rsp_taken_o,
    input  upd_ready_o,
    input  tbl_req_o, tbl_we_o, tbl_addr_o, tbl_wdata_o
  );
endinterface

// File: rtl/bp_table_arbiter.sv
// Purpose: owns the single-port 2-bit PHT; clears it after reset, then arbitrates fetch lookups
//          against queued resolved-branch updates (applied as read-modify-write).
// Latency: lookup response 1 cycle after lkp_ready_o; an update costs a read cycle plus a write cycle.
// Backpressure: lkp_ready_o drops during INIT, when an update wins, and in UPD_WR;
//               upd_ready_o drops while the update FIFO is full.
// Ports: clk_i, rst_ni (synchronous, active-high despite the name), bus (slave modport) carrying
//        flush_i, lookup req/rsp, update req, table port and init_done_o.
module bp_table_arbiter #(
  parameter int IDX_W      = 8,
  parameter int UPD_DEPTH  = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  bp_table_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(UPD_DEPTH);
  localparam int CNT_W = $clog2(UPD_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(UPD_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  // Counter encoding: bit 1 clear means predict taken.
  typedef enum logic [1:0] {
    WEAK_TAKEN    = 2'd0,
    STRONG_TAKEN  = 2'd1,
    WEAK_NTAKEN   = 2'd2,
    STRONG_NTAKEN = 2'd3
  } ctr_t;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_UPD_WR = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_ent_t;

  // Saturating transition rules of the 2-bit counter.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken) begin
      case (cur)
        STRONG_NTAKEN: nxt = WEAK_NTAKEN;
        WEAK_NTAKEN:   nxt = WEAK_TAKEN;
        WEAK_TAKEN:    nxt = STRONG_TAKEN;
        default:       nxt = STRONG_TAKEN;
      endcase
    end else begin
      case (cur)
        STRONG_TAKEN:  nxt = WEAK_TAKEN;
        WEAK_TAKEN:    nxt = WEAK_NTAKEN;
        WEAK_NTAKEN:   nxt = STRONG_NTAKEN;
        default:       nxt = STRONG_NTAKEN;
      endcase
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q;
  logic             init_done_q;
  logic             rsp_vld_q;
  logic [STV_W-1:0] starve_q;

  upd_ent_t         fifo_mem [UPD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  // ---------------------------------------------------------------------------
  // FIFO status
  // ---------------------------------------------------------------------------
  logic     fifo_full;
  logic     fifo_nempty;
  logic     push;
  logic     pop;
  upd_ent_t head;
  upd_ent_t push_ent;

  assign fifo_full   = (cnt_q == CNT_FULL);
  assign fifo_nempty = (cnt_q != '0);
  assign head        = fifo_mem[rd_ptr_q];
  assign push_ent    = '{idx: bus.upd_idx_i, taken: bus.upd_taken_i};
  // A push in a flush cycle is dropped along with the rest of the queue.
  assign push        = bus.upd_valid_i && !fifo_full && !bus.flush_i;

  // ---------------------------------------------------------------------------
  // Next state, arbitration and table command
  // ---------------------------------------------------------------------------
  logic             sel_upd;
  logic             sel_lkp;
  logic             lkp_rdy;
  logic             tbl_req;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  ctr_t             tbl_wdata;

  always_comb begin
    state_d   = state_q;
    sel_upd   = 1'b0;
    sel_lkp   = 1'b0;
    lkp_rdy   = 1'b0;
    pop       = 1'b0;
    tbl_req   = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = WEAK_TAKEN;

    case (state_q)
      ST_INIT: begin
        tbl_req   = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = init_idx_q;
        tbl_wdata = WEAK_NTAKEN;
        if (init_idx_q == IDX_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // An update is not started in a flush cycle: the queue it would read is being discarded.
        if (fifo_nempty && !bus.flush_i &&
            (!bus.lkp_valid_i || fifo_full || (starve_q == STV_MAX))) begin
          sel_upd  = 1'b1;
          tbl_req  = 1'b1;
          tbl_addr = head.idx;
          state_d  = ST_UPD_WR;
        end else if (bus.lkp_valid_i) begin
          sel_lkp  = 1'b1;
          lkp_rdy  = 1'b1;
          tbl_req  = 1'b1;
          tbl_addr = bus.lkp_idx_i;
        end
      end

      ST_UPD_WR: begin
        // Read data for the head entry arrives this cycle; write back the advanced counter.
        tbl_req   = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = head.idx;
        tbl_wdata = ctr_next(ctr_t'(bus.tbl_rdata_i), head.taken);
        pop       = 1'b1;
        state_d   = ST_RUN;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      state_q     <= ST_INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      rsp_vld_q   <= 1'b0;
      starve_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q   <= state_d;
      rsp_vld_q <= sel_lkp;

      if (state_q == ST_INIT) begin
        init_idx_q <= init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_LAST) begin
          init_done_q <= 1'b1;
        end
      end

      // Flush drops everything queued; a pop from an in-flight write is absorbed.
      if (bus.flush_i) begin
        cnt_q    <= '0;
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end

      // Counts lookups that beat a waiting update; saturates at STARVE_MAX.
      if (bus.flush_i || sel_upd) begin
        starve_q <= '0;
      end else if (sel_lkp && fifo_nempty && (starve_q != STV_MAX)) begin
        starve_q <= starve_q + STV_W'(1);
      end
    end
  end

  // Queue storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_ent;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs; command strobes are held low while reset is asserted so an
  // interrupted write is abandoned immediately.
  // ---------------------------------------------------------------------------
  assign bus.tbl_req_o       = tbl_req & !rst_ni;
  assign bus.tbl_we_o        = tbl_we & !rst_ni;
  assign bus.tbl_addr_o      = tbl_addr;
  assign bus.tbl_wdata_o     = tbl_wdata;
  assign bus.lkp_ready_o     = lkp_rdy & !rst_ni;
  assign bus.upd_ready_o     = rst_ni | !fifo_full;
  assign bus.init_done_o     = init_done_q;
  assign bus.lkp_rsp_valid_o = rsp_vld_q;
  assign bus.lkp_rsp_state_o = rsp_vld_q ? bus.tbl_rdata_i : 2'd0;
  assign bus.lkp_rsp_taken_o = rsp_vld_q & !bus.tbl_rdata_i[1];

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_ni) cnt_q <= CNT_FULL);
  a_stv_bound : assert property (@(posedge clk_i) disable iff (rst_ni) starve_q <= STV_MAX);
  a_wr_has_ent: assert property (@(posedge clk_i) disable iff (rst_ni)
                                 (state_q == ST_UPD_WR) |-> fifo_nempty);

endmodule

// File: tb/tb_bp_table_arbiter.sv
module tb_bp_table_arbiter;
  localparam int IDX_W = 4;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic mem_clr;
  int   checks   = 0;
  int   failures = 0;

  bp_table_arbiter_if #(.IDX_W(IDX_W)) bus ();

  bp_table_arbiter #(
    .IDX_W(IDX_W),
    .UPD_DEPTH(4),
    .STARVE_MAX(7)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Table model: one-cycle read latency, starts filled with 3 so the clear sweep is visible.
  logic [1:0] mem [16];
  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 2'd3;
      bus.tbl_rdata_i <= 2'd0;
    end else if (bus.tbl_req_o) begin
      if (bus.tbl_we_o) mem[bus.tbl_addr_o] <= bus.tbl_wdata_o;
      else              bus.tbl_rdata_i <= mem[bus.tbl_addr_o];
    end
  end

  wire [7:0] acc_w = {bus.tbl_req_o, bus.tbl_we_o, bus.tbl_addr_o, bus.tbl_wdata_o};
  wire [5:0] acc_r = {bus.tbl_req_o, bus.tbl_we_o, bus.tbl_addr_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, then settle before checks.
  task automatic step(input logic rst, input logic lv, input logic [3:0] li,
                      input logic uv, input logic [3:0] ui, input logic ut, input logic fl);
    @(negedge clk_i);
    rst_ni          = rst;
    bus.lkp_valid_i = lv;
    bus.lkp_idx_i   = li;
    bus.upd_valid_i = uv;
    bus.upd_idx_i   = ui;
    bus.upd_taken_i = ut;
    bus.flush_i     = fl;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni          = 1'b1;
    mem_clr         = 1'b1;
    bus.flush_i     = 1'b0;
    bus.lkp_valid_i = 1'b0;
    bus.lkp_idx_i   = '0;
    bus.upd_valid_i = 1'b0;
    bus.upd_idx_i   = '0;
    bus.upd_taken_i = 1'b0;

    // Reset state (a lookup request is held to show it is not accepted).
    step(1, 1, 4'd5, 0, 0, 0, 0);
    chk("rst_req",       32'(bus.tbl_req_o), 32'd0);
    chk("rst_lkp_rdy",   32'(bus.lkp_ready_o), 32'd0);
    chk("rst_rsp_vld",   32'(bus.lkp_rsp_valid_o), 32'd0);
    chk("rst_upd_rdy",   32'(bus.upd_ready_o), 32'd1);
    chk("rst_init_done", 32'(bus.init_done_o), 32'd0);

    // Clear sweep: 16 writes of WEAK_NTAKEN to 0..15, no lookup accepted.
    for (int i = 0; i < 16; i++) begin
      mem_clr = 1'b0;
      step(0, 1, 4'd5, 0, 0, 0, 0);
      chk("init_wr",   32'(acc_w), 32'({1'b1, 1'b1, 4'(i), 2'd2}));
      chk("init_rdy",  32'(bus.lkp_ready_o), 32'd0);
      chk("init_done", 32'(bus.init_done_o), 32'd0);
    end

    // Cycle 17: init done, first lookup accepted.
    step(0, 1, 4'd5, 0, 0, 0, 0);
    chk("done_rise", 32'(bus.init_done_o), 32'd1);
    chk("lkp5_rdy",  32'(bus.lkp_ready_o), 32'd1);
    chk("lkp5_rd",   32'(acc_r), 32'({1'b1, 1'b0, 4'd5}));
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lkp5_vld",   32'(bus.lkp_rsp_valid_o), 32'd1);
    chk("lkp5_state", 32'(bus.lkp_rsp_state_o), 32'd2);
    chk("lkp5_taken", 32'(bus.lkp_rsp_taken_o), 32'd0);

    // Three taken updates to idx 5: 2 -> 0 -> 1 -> 1.
    step(0, 0, 0, 1, 4'd5, 1, 0);
    chk("u1_idle",    32'(bus.tbl_req_o), 32'd0);
    chk("u1_upd_rdy", 32'(bus.upd_ready_o), 32'd1);
    step(0, 0, 0, 1, 4'd5, 1, 0);
    chk("u1_rd", 32'(acc_r), 32'({1'b1, 1'b0, 4'd5}));
    step(0, 0, 0, 1, 4'd5, 1, 0);
    chk("u1_wr", 32'(acc_w), 32'({1'b1, 1'b1, 4'd5, 2'd0}));
    step(0, 0, 0, 0, 0, 0, 0);
    chk("u2_rd", 32'(acc_r), 32'({1'b1, 1'b0, 4'd5}));
    step(0, 0, 0, 0, 0, 0, 0);
    chk("u2_wr", 32'(acc_w), 32'({1'b1, 1'b1, 4'd5, 2'd1}));
    step(0, 0, 0, 0, 0, 0, 0);
    chk("u3_rd", 32'(acc_r), 32'({1'b1, 1'b0, 4'd5}));
    step(0, 0, 0, 0, 0, 0, 0);
    chk("u3_wr_sat", 32'(acc_w), 32'({1'b1, 1'b1, 4'd5, 2'd1}));
    step(0, 0, 0, 0, 0, 0, 0);
    chk("u_done_idle", 32'(bus.tbl_req_o), 32'd0);
    step(0, 1, 4'd5, 0, 0, 0, 0);
    chk("lkp5b_rdy", 32'(bus.lkp_ready_o), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lkp5b_state", 32'(bus.lkp_rsp_state_o), 32'd1);
    chk("lkp5b_taken", 32'(bus.lkp_rsp_taken_o), 32'd1);

    // Starvation: one not-taken update to idx 9 against continuous lookups.
    step(0, 1, 4'd3, 1, 4'd9, 0, 0);
    chk("stv_p0_rdy", 32'(bus.lkp_ready_o), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      step(0, 1, 4'd3, 0, 0, 0, 0);
      chk("stv_lkp_wins", 32'(bus.lkp_ready_o), 32'd1);
      if (k == 1) chk("lkp3_state", 32'(bus.lkp_rsp_state_o), 32'd2);
    end
    step(0, 1, 4'd3, 0, 0, 0, 0);
    chk("stv8_rdy", 32'(bus.lkp_ready_o), 32'd0);
    chk("stv8_rd",  32'(acc_r), 32'({1'b1, 1'b0, 4'd9}));
    step(0, 1, 4'd3, 0, 0, 0, 0);
    chk("stv9_rdy", 32'(bus.lkp_ready_o), 32'd0);
    chk("stv9_wr",  32'(acc_w), 32'({1'b1, 1'b1, 4'd9, 2'd3}));
    step(0, 1, 4'd3, 0, 0, 0, 0);
    chk("stv10_rdy", 32'(bus.lkp_ready_o), 32'd1);

    // Fill the FIFO (10..13) under continuous lookups; a 5th push is refused.
    for (int q = 0; q < 4; q++) begin
      step(0, 1, 4'd3, 1, 4'(10 + q), 1, 0);
      chk("fill_lkp_rdy", 32'(bus.lkp_ready_o), 32'd1);
      chk("fill_upd_rdy", 32'(bus.upd_ready_o), 32'd1);
    end
    step(0, 1, 4'd3, 1, 4'd14, 1, 0);
    chk("full_upd_rdy", 32'(bus.upd_ready_o), 32'd0);
    chk("full_lkp_rdy", 32'(bus.lkp_ready_o), 32'd0);
    chk("full_rd",      32'(acc_r), 32'({1'b1, 1'b0, 4'd10}));
    step(0, 1, 4'd3, 0, 0, 0, 0);
    chk("full_wr",      32'(acc_w), 32'({1'b1, 1'b1, 4'd10, 2'd0}));
    chk("full_wr_rdy",  32'(bus.lkp_ready_o), 32'd0);
    step(0, 1, 4'd3, 0, 0, 0, 0);
    chk("after_full_lkp", 32'(bus.lkp_ready_o), 32'd1);
    chk("after_full_upd", 32'(bus.upd_ready_o), 32'd1);

    // Flush while idx 11 is being written, 12 and 13 still queued.
    step(0, 0, 0, 0, 0, 0, 0);
    chk("fl_rd", 32'(acc_r), 32'({1'b1, 1'b0, 4'd11}));
    step(0, 0, 0, 0, 0, 0, 1);
    chk("fl_wr", 32'(acc_w), 32'({1'b1, 1'b1, 4'd11, 2'd0}));
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("fl_idle",    32'(bus.tbl_req_o), 32'd0);
      chk("fl_upd_rdy", 32'(bus.upd_ready_o), 32'd1);
    end
    chk("mem11", 32'(mem[11]), 32'd0);
    chk("mem12", 32'(mem[12]), 32'd2);
    chk("mem14", 32'(mem[14]), 32'd2);

    // Reset mid-update: queue lost, sweep restarts at 0.
    step(0, 0, 0, 1, 4'd1, 1, 0);
    step(0, 0, 0, 1, 4'd2, 1, 0);
    chk("mr_rd", 32'(acc_r), 32'({1'b1, 1'b0, 4'd1}));
    step(1, 0, 0, 0, 0, 0, 0);
    chk("mr_req",     32'(bus.tbl_req_o), 32'd0);
    chk("mr_upd_rdy", 32'(bus.upd_ready_o), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("mr_init0",   32'(acc_w), 32'({1'b1, 1'b1, 4'd0, 2'd2}));
    chk("mr_done",    32'(bus.init_done_o), 32'd0);
    chk("mr_rsp_vld", 32'(bus.lkp_rsp_valid_o), 32'd0);
    for (int i = 1; i < 16; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("mr_init15", 32'(acc_w), 32'({1'b1, 1'b1, 4'd15, 2'd2}));
    step(0, 0, 0, 0, 0, 0, 0);
    chk("mr_done2",  32'(bus.init_done_o), 32'd1);
    chk("mr_q_lost", 32'(bus.tbl_req_o), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("mr_q_lost2", 32'(bus.tbl_req_o), 32'd0);
    chk("mem1", 32'(mem[1]), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bp_table_arbiter.md
Name: bp_table_arbiter

Overview:
- Controller and arbiter for the single-port 2-bit branch pattern history table (PHT) used by the fetch-stage dynamic predictor.
- Shares the table port between two requesters:
  - fetch lookups, which are latency-critical;
  - resolved-branch updates from execute, queued and applied as read-modify-write.
- Runs a clear sweep after reset.
- Owns the counter state encoding and the saturating transition rules.

Parameters:
- IDX_W, 8, PHT index width; table holds 2**IDX_W entries.
- UPD_DEPTH, 4, update FIFO depth; power of two, >= 2.
- STARVE_MAX, 7, maximum consecutive lost arbitrations before updates take priority; >= 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous reset, active-high (1 = reset).
- flush_i  in  1  discard all queued updates not yet started.
- lkp_valid_i  in  1  fetch lookup request.
- lkp_idx_i  in  IDX_W  lookup index.
- lkp_ready_o  out  1  lookup accepted this cycle.
- lkp_rsp_valid_o  out  1  lookup response valid.
- lkp_rsp_state_o  out  2  counter state read.
- lkp_rsp_taken_o  out  1  predict taken.
- upd_valid_i  in  1  resolved branch update.
- upd_idx_i  in  IDX_W  update index.
- upd_taken_i  in  1  actual outcome.
- upd_ready_o  out  1  update FIFO can accept.
- tbl_req_o  out  1  table access.
- tbl_we_o  out  1  write enable.
- tbl_addr_o  out  IDX_W  table address.
- tbl_wdata_o  out  2  write data.
- tbl_rdata_i  in  2  read data; valid the cycle after a read request.
- init_done_o  out  1  clear sweep finished.

Behaviour:
- Counter encoding:
  - WEAK_TAKEN = 0, STRONG_TAKEN = 1, WEAK_NTAKEN = 2, STRONG_NTAKEN = 3.
  - Predict taken when state is 0 or 1.
- Saturating transitions:
  - Taken: STRONG_NTAKEN → WEAK_NTAKEN → WEAK_TAKEN → STRONG_TAKEN → STRONG_TAKEN.
  - Not taken: STRONG_TAKEN → WEAK_TAKEN → WEAK_NTAKEN → STRONG_NTAKEN → STRONG_NTAKEN.
- Reset values:
  - FSM = INIT; init index = 0; FIFO empty; starve counter = 0.
  - All outputs 0, except upd_ready_o = 1.
- FSM states: INIT, RUN, UPD_WR.
- INIT:
  - Each cycle writes WEAK_NTAKEN (2) to the init index, then increments it.
  - After writing index 2**IDX_W-1, goes to RUN; init_done_o = 1 from the next cycle, held until reset.
  - lkp_ready_o = 0 throughout.
  - Updates may be queued during INIT.
- RUN arbitration, each cycle:
  - The update is selected if the FIFO is non-empty and any of these holds:
    - lkp_valid_i = 0;
    - the FIFO is full;
    - the starve counter equals STARVE_MAX.
  - Otherwise a valid lookup is selected.
- Lookup selected:
  - lkp_ready_o = 1; read issued at lkp_idx_i.
  - Next cycle: lkp_rsp_valid_o = 1, lkp_rsp_state_o = tbl_rdata_i, taken decoded from it.
  - Lookup latency is 1 cycle.
- Update selected:
  - Read issued at the FIFO head index; go to UPD_WR.
  - Starve counter cleared.
- Starve counter:
  - Increments (saturating) in each RUN cycle where the FIFO is non-empty and the lookup wins.
- UPD_WR:
  - Writes next_state(tbl_rdata_i, head taken) to the head index.
  - Pops the FIFO; returns to RUN.
  - lkp_ready_o = 0.
- No forwarding:
  - A lookup may observe the pre-update value of an in-progress or queued update.
  - Permitted: prediction only.
- FIFO:
  - upd_ready_o = !full, computed from the registered count.
  - Push when upd_valid_i & upd_ready_o.
  - Push and pop in the same cycle are allowed; count unchanged.
  - Pointers wrap modulo UPD_DEPTH.
- flush_i:
  - Empties the FIFO next cycle; a push in the flush cycle is discarded.
  - An update already in UPD_WR still completes its write; its pop is absorbed, so the count stays 0.
  - Starve counter cleared.
- Reset asserted mid-operation:
  - Any in-flight read or write is abandoned and the queue is lost.
  - INIT restarts from index 0.
- At most one table access per cycle.
- tbl_req_o = 0 when idle; tbl_addr_o and tbl_wdata_o are don't-care when tbl_req_o = 0.

Test Plan:
- Reset, IDX_W=4 → 16 consecutive writes of 2 to addresses 0..15; init_done_o rises on cycle 17; no lkp_ready_o before it.
- After init, lookup idx 5 with no updates → lkp_ready_o = 1; next cycle rsp_state = 2, rsp_taken = 0.
- Three updates to idx 5, all taken, with no lookups:
  - Table sequence 2→0→1, then saturates at 1.
  - Each update takes a read cycle plus a write cycle.
  - A subsequent lookup returns state 1, taken = 1.
- Continuous lookups with one queued update, STARVE_MAX=7 → update wins on the 8th contended cycle; lkp_ready_o = 0 for that cycle and for the following UPD_WR cycle.
- Push 4 updates while lookups run continuously (UPD_DEPTH=4) → upd_ready_o = 0 when full; next RUN cycle selects the update regardless of lookups.
- flush_i raised during UPD_WR with 3 queued updates → in-flight write completes; FIFO empty afterwards; no further table writes; upd_ready_o = 1.
